// File: rtl/huffman_encoder.sv
// ---------------------------------------------------------------------------
// huffman_encoder
//   Stream-loaded Huffman encoder. The host steps in a code table
//   (character -> code/length) and a zero-terminated message, one entry per
//   step. The block then packs the codes MSB-first into 32-bit words. The
//   top 16 bits of word 0 hold the payload bit count, and the payload starts
//   at bit 15 of word 0. The host reads the words back one per step.
//
// Ports
//   clock          in   1  system clock, rising edge
//   reset          in   1  synchronous active-high clear
//   clockEnable    in   1  step strobe (rising level = one step)
//   messageLoaded  in   1  message stream complete (sampled on a step)
//   dataLoaded     in   1  table stream complete (sampled on a step)
//   manualReset    in   1  synchronous clear, same effect as reset
//   symbol         in  32  code bits, right-aligned
//   symbolLength   in   8  code length (>32 clamps to 32, 0 emits nothing)
//   character      in   8  table key
//   message        in   8  message byte
//   dataReady      out 16  number of valid output words once encoding is done
//   dataOut        out 32  output word register
//   log            out 16  {state[15:12], message count[11:6], table writes[5:0]}
// ---------------------------------------------------------------------------
module huffman_encoder #(
    parameter int MAX_MSG   = 63,
    parameter int MAX_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clockEnable,
    input  logic        messageLoaded,
    input  logic        dataLoaded,
    input  logic        manualReset,
    input  logic [31:0] symbol,
    input  logic [7:0]  symbolLength,
    input  logic [7:0]  character,
    input  logic [7:0]  message,
    output logic [15:0] dataReady,
    output logic [31:0] dataOut,
    output logic [15:0] log
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Payload room: the whole buffer minus the 16-bit header.
    localparam logic [11:0] MAX_PAYLOAD = 12'(MAX_WORDS * 32 - 16);
    localparam logic [5:0]  MSG_LIMIT   = 6'(MAX_MSG);

    // Code table, indexed by character.
    logic [31:0] tab_sym_r [0:255];
    logic [5:0]  tab_len_r [0:255];
    logic        tab_vld_r [0:255];

    logic [7:0]  msg_mem_r  [0:63];
    logic [31:0] word_mem_r [0:MAX_WORDS-1];

    logic [1:0]  state_r;
    logic        ce_prev_r;
    logic        tab_hdr_r;
    logic        tab_frozen_r;
    logic [5:0]  tab_cnt_r;
    logic        msg_hdr_r;
    logic        msg_term_r;
    logic        msg_done_r;
    logic [5:0]  msg_cnt_r;
    logic [5:0]  enc_idx_r;
    logic [5:0]  bit_idx_r;
    logic [11:0] payload_r;
    logic [6:0]  rd_ptr_r;
    logic [15:0] data_ready_r;
    logic [31:0] data_out_r;

    logic        clr_s;
    logic        step_s;
    logic [5:0]  len_clamped_s;
    logic        tab_wr_s;
    logic        msg_wr_s;
    logic [7:0]  cur_char_s;
    logic [5:0]  cur_len_s;
    logic [5:0]  len_m1_s;
    logic [5:0]  bit_sel_s;
    logic        cur_bit_s;
    logic        last_bit_s;
    logic        enc_end_s;
    logic [11:0] wr_pos_s;
    logic [15:0] dr_calc_s;

    // Step detection, clamping and load-stream write enables.
    always_comb begin
        clr_s         = reset | manualReset;
        step_s        = clockEnable & ~ce_prev_r;
        if (symbolLength > 8'd32) begin
            len_clamped_s = 6'd32;
        end else begin
            len_clamped_s = symbolLength[5:0];
        end
        tab_wr_s = !clr_s && (state_r == ST_LOAD) && step_s && !dataLoaded &&
                   !tab_frozen_r && tab_hdr_r;
        msg_wr_s = !clr_s && (state_r == ST_LOAD) && step_s && !messageLoaded &&
                   !msg_term_r && msg_hdr_r && (message != 8'd0) &&
                   (msg_cnt_r < MSG_LIMIT);
    end

    // Encoder datapath: current character's code and the bit to emit now.
    always_comb begin
        cur_char_s = msg_mem_r[enc_idx_r];
        if (tab_vld_r[cur_char_s]) begin
            cur_len_s = tab_len_r[cur_char_s];
        end else begin
            cur_len_s = 6'd0;
        end
        len_m1_s   = cur_len_s - 6'd1;
        bit_sel_s  = len_m1_s - bit_idx_r;
        cur_bit_s  = tab_sym_r[cur_char_s][bit_sel_s[4:0]];
        last_bit_s = (bit_idx_r == len_m1_s);
        enc_end_s  = (enc_idx_r == msg_cnt_r) || (payload_r == MAX_PAYLOAD);
        wr_pos_s   = payload_r + 12'd16;
        // ceil((16 + payload) / 32)
        dr_calc_s  = {4'd0, payload_r} + 16'd47;
    end

    // Table code/length storage; validity lives with the resettable state.
    always_ff @(posedge clock) begin
        if (tab_wr_s) begin
            tab_sym_r[character] <= symbol;
            tab_len_r[character] <= len_clamped_s;
        end
    end

    // Message byte storage.
    always_ff @(posedge clock) begin
        if (msg_wr_s) begin
            msg_mem_r[msg_cnt_r] <= message;
        end
    end

    // Control FSM, load bookkeeping, bit packing and read-out.
    always_ff @(posedge clock) begin
        if (clr_s) begin
            state_r      <= ST_LOAD;
            ce_prev_r    <= 1'b1;   // a held-high strobe must not step
            tab_hdr_r    <= 1'b0;
            tab_frozen_r <= 1'b0;
            tab_cnt_r    <= 6'd0;
            msg_hdr_r    <= 1'b0;
            msg_term_r   <= 1'b0;
            msg_done_r   <= 1'b0;
            msg_cnt_r    <= 6'd0;
            enc_idx_r    <= 6'd0;
            bit_idx_r    <= 6'd0;
            payload_r    <= 12'd0;
            rd_ptr_r     <= 7'd0;
            data_ready_r <= 16'd0;
            data_out_r   <= 32'd0;
            for (int i = 0; i < 256; i++) begin
                tab_vld_r[i] <= 1'b0;
            end
            for (int i = 0; i < MAX_WORDS; i++) begin
                word_mem_r[i] <= 32'd0;
            end
        end else begin
            ce_prev_r <= clockEnable;
            case (state_r)
                ST_LOAD: begin
                    if (step_s) begin
                        // Table stream: first step is a header and is dropped.
                        if (dataLoaded) begin
                            tab_frozen_r <= 1'b1;
                        end else if (!tab_frozen_r && !tab_hdr_r) begin
                            tab_hdr_r <= 1'b1;
                        end
                        if (tab_wr_s) begin
                            tab_vld_r[character] <= 1'b1;
                            if (tab_cnt_r != 6'd63) begin
                                tab_cnt_r <= tab_cnt_r + 6'd1;
                            end
                        end
                        // Message stream: header first, 0x00 terminates.
                        if (messageLoaded) begin
                            msg_done_r <= 1'b1;
                        end else if (!msg_term_r) begin
                            if (!msg_hdr_r) begin
                                msg_hdr_r <= 1'b1;
                            end else if (message == 8'd0) begin
                                msg_term_r <= 1'b1;
                            end
                        end
                        if (msg_wr_s) begin
                            msg_cnt_r <= msg_cnt_r + 6'd1;
                        end
                    end
                    if (tab_frozen_r && msg_done_r) begin
                        state_r <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (enc_end_s) begin
                        // Header goes into the top half of word 0 last.
                        word_mem_r[0][31:16] <= {4'd0, payload_r};
                        data_ready_r         <= {5'd0, dr_calc_s[15:5]};
                        state_r              <= ST_DONE;
                    end else if (bit_idx_r >= cur_len_s) begin
                        // Unknown or zero-length character: skip it.
                        enc_idx_r <= enc_idx_r + 6'd1;
                        bit_idx_r <= 6'd0;
                    end else begin
                        word_mem_r[wr_pos_s[10:5]][5'd31 - wr_pos_s[4:0]] <= cur_bit_s;
                        payload_r <= payload_r + 12'd1;
                        if (last_bit_s) begin
                            enc_idx_r <= enc_idx_r + 6'd1;
                            bit_idx_r <= 6'd0;
                        end else begin
                            bit_idx_r <= bit_idx_r + 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (step_s) begin
                        if ({9'd0, rd_ptr_r} < data_ready_r) begin
                            data_out_r <= word_mem_r[rd_ptr_r[5:0]];
                        end else begin
                            data_out_r <= 32'd0;
                        end
                        if (rd_ptr_r < 7'd64) begin
                            rd_ptr_r <= rd_ptr_r + 7'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    assign dataReady = data_ready_r;
    assign dataOut   = data_out_r;
    assign log       = {2'b00, state_r, msg_cnt_r, tab_cnt_r};

endmodule

// File: tb/tb_huffman_encoder.sv
// ---------------------------------------------------------------------------
// tb_huffman_encoder
//   Directed bench for huffman_encoder. Expected output words are queued when
//   a load sequence is driven and popped as the words are read back.
// ---------------------------------------------------------------------------
module tb_huffman_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clockEnable = 1'b0;
    logic        messageLoaded = 1'b0;
    logic        dataLoaded = 1'b0;
    logic        manualReset = 1'b0;
    logic [31:0] symbol = 32'd0;
    logic [7:0]  symbolLength = 8'd0;
    logic [7:0]  character = 8'd0;
    logic [7:0]  message = 8'd0;
    logic [15:0] dataReady;
    logic [31:0] dataOut;
    logic [15:0] log;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    logic [8*11-1:0] text    = "ALA MA KOTA";
    logic [8*20-1:0] fillers = "BCDEFGHIJNPQRSUVWXYZ";

    huffman_encoder dut (
        .clock        (clock),
        .reset        (reset),
        .clockEnable  (clockEnable),
        .messageLoaded(messageLoaded),
        .dataLoaded   (dataLoaded),
        .manualReset  (manualReset),
        .symbol       (symbol),
        .symbolLength (symbolLength),
        .character    (character),
        .message      (message),
        .dataReady    (dataReady),
        .dataOut      (dataOut),
        .log          (log)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        clockEnable = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // One host step: inputs set and strobe raised at a falling edge,
    // strobe dropped at the next falling edge.
    task automatic step(input logic dl, input logic ml, input logic [7:0] ch,
                        input logic [31:0] sym, input logic [7:0] len,
                        input logic [7:0] msg);
        @(negedge clock);
        dataLoaded    = dl;
        messageLoaded = ml;
        character     = ch;
        symbol        = sym;
        symbolLength  = len;
        message       = msg;
        clockEnable   = 1'b1;
        @(negedge clock);
        clockEnable   = 1'b0;
    endtask

    task automatic get_entry(input int i, output logic [7:0] ch,
                             output logic [31:0] sym, output logic [7:0] len);
        case (i)
            0: begin ch = 8'h20; sym = 32'd0;  len = 8'd0; end
            1: begin ch = 8'h41; sym = 32'd14; len = 8'd4; end
            2: begin ch = 8'h4C; sym = 32'd30; len = 8'd5; end
            3: begin ch = 8'h4D; sym = 32'd7;  len = 8'd5; end
            4: begin ch = 8'h4B; sym = 32'd23; len = 8'd7; end
            5: begin ch = 8'h4F; sym = 32'd13; len = 8'd6; end
            6: begin ch = 8'h54; sym = 32'd0;  len = 8'd3; end
            default: begin
                ch  = fillers[8*(26-i) +: 8];
                sym = 32'(i);
                len = 8'd8;
            end
        endcase
    endtask

    // "ALA MA KOTA" with a 27-entry table; extra adds ignored traffic.
    task automatic load_main(input bit extra);
        logic [7:0]  ch;
        logic [31:0] sym;
        logic [7:0]  len;
        logic [7:0]  mb;
        step(1'b0, 1'b0, 8'h00, 32'd0, 8'd0, 8'd37);
        for (int i = 0; i < 27; i++) begin
            get_entry(i, ch, sym, len);
            if (i < 11) begin
                mb = text[8*(10-i) +: 8];
            end else if (i == 11) begin
                mb = 8'h00;
            end else begin
                mb = 8'h55;
            end
            step(1'b0, 1'b0, ch, sym, len, mb);
        end
        if (extra) begin
            step(1'b1, 1'b0, 8'h41, 32'd0, 8'd8, 8'h41);
            step(1'b0, 1'b0, 8'h41, 32'd0, 8'd8, 8'h4B);
            step(1'b0, 1'b1, 8'h4D, 32'd0, 8'd8, 8'h4D);
        end else begin
            step(1'b1, 1'b1, 8'h00, 32'd0, 8'd0, 8'h00);
        end
        exp_q.push_back(32'h002AEF71);
        exp_q.push_back(32'hF8B9A380);
        exp_q.push_back(32'h00000000);
    endtask

    task automatic load_single(input logic [7:0] len);
        step(1'b0, 1'b0, 8'h00, 32'd0, 8'd0, 8'd1);
        step(1'b0, 1'b0, 8'h5A, 32'hFFFFFFFF, len, 8'h5A);
        step(1'b1, 1'b0, 8'h00, 32'd0, 8'd0, 8'h00);
        step(1'b1, 1'b1, 8'h00, 32'd0, 8'd0, 8'h00);
        exp_q.push_back(32'h0020FFFF);
        exp_q.push_back(32'hFFFF0000);
        exp_q.push_back(32'h00000000);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (log[15:12] == 4'd2) got = 1'b1;
        end
        check("done_reached", {31'd0, got}, 32'd1);
    endtask

    task automatic read_all(input string tag);
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            step(1'b0, 1'b0, 8'h00, 32'd0, 8'd0, 8'h00);
            e = exp_q.pop_front();
            check(tag, dataOut, e);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_dataReady", {16'd0, dataReady}, 32'd0);
        check("rst_dataOut", dataOut, 32'd0);
        check("rst_log", {16'd0, log}, 32'd0);

        // Held-high strobe for 10 clocks is a single (header) step
        @(negedge clock);
        character = 8'h41; symbol = 32'd14; symbolLength = 8'd4; message = 8'h41;
        clockEnable = 1'b1;
        repeat (10) @(negedge clock);
        clockEnable = 1'b0;
        check("hold_one_step", {16'd0, log}, 32'd0);
        step(1'b0, 1'b0, 8'h41, 32'd14, 8'd4, 8'h41);
        check("second_step", {16'd0, log}, {16'd0, 4'd0, 6'd1, 6'd1});

        // Reset with strobe held high must not produce a step
        @(negedge clock);
        clockEnable = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        clockEnable = 1'b0;
        check("primed_log", {16'd0, log}, 32'd0);
        step(1'b0, 1'b0, 8'h41, 32'd14, 8'd4, 8'h41);
        check("primed_header", {16'd0, log}, 32'd0);

        // Main message
        do_reset();
        load_main(1'b0);
        wait_done();
        check("main_log", {16'd0, log}, {16'd0, 4'd2, 6'd11, 6'd27});
        check("main_dataReady", {16'd0, dataReady}, 32'd2);
        read_all("main_word");
        step(1'b0, 1'b0, 8'h00, 32'd0, 8'd0, 8'h00);
        check("main_past_end", dataOut, 32'd0);

        // Empty message
        do_reset();
        step(1'b0, 1'b0, 8'h00, 32'd0, 8'd0, 8'd1);
        step(1'b0, 1'b0, 8'h00, 32'd0, 8'd0, 8'h00);
        step(1'b1, 1'b1, 8'h00, 32'd0, 8'd0, 8'h00);
        exp_q.push_back(32'h00000000);
        wait_done();
        check("empty_dataReady", {16'd0, dataReady}, 32'd1);
        read_all("empty_word");

        // Single 32-bit code, then an over-long length that must clamp
        do_reset();
        load_single(8'd32);
        wait_done();
        check("single_dataReady", {16'd0, dataReady}, 32'd2);
        read_all("single_word");
        do_reset();
        load_single(8'd200);
        wait_done();
        check("clamp_dataReady", {16'd0, dataReady}, 32'd2);
        read_all("clamp_word");

        // Table writes after freeze and bytes after terminator are ignored
        do_reset();
        load_main(1'b1);
        wait_done();
        check("ignore_dataReady", {16'd0, dataReady}, 32'd2);
        read_all("ignore_word");

        // manualReset in the middle of encoding
        do_reset();
        load_main(1'b0);
        repeat (3) @(negedge clock);
        check("mid_state_encode", {28'd0, log[15:12]}, 32'd1);
        manualReset = 1'b1;
        @(negedge clock);
        manualReset = 1'b0;
        exp_q.delete();
        check("mrst_log", {16'd0, log}, 32'd0);
        check("mrst_dataReady", {16'd0, dataReady}, 32'd0);
        load_main(1'b0);
        wait_done();
        check("reload_dataReady", {16'd0, dataReady}, 32'd2);
        read_all("reload_word");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
